// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the div128by64 divider.
//   div_state_t : FSM state encoding (IDLE, RUN, DONE)
//   DIV_W       : default operand width
//   quot_sat()  : saturated quotient (all-ones) returned on div-by-zero / overflow
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  localparam int unsigned DIV_W = 64;

  // All-ones in the low w bits; callers cast down to their own quotient width.
  function automatic logic [DIV_W-1:0] quot_sat(input int unsigned w);
    logic [DIV_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < DIV_W; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division step.
//   rem_i     : partial remainder (always < divisor_i on entry)
//   bit_i     : next dividend bit shifted in at the bottom
//   divisor_i : divisor
//   rem_o     : new partial remainder (< divisor_i)
//   q_o       : quotient bit produced by this step
module div_step #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] t;

  always_comb begin
    t   = {rem_i, bit_i};
    q_o = (t >= {1'b0, divisor_i});
    // The difference is below the divisor, so it always fits in W bits.
    rem_o = q_o ? W'(t - {1'b0, divisor_i}) : t[W-1:0];
  end

endmodule

// File: rtl/div128by64.sv
// div128by64: multi-cycle unsigned 2W/W divider (restoring, valid/ready on both sides).
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : operand handshake; dividend (2W bits), divisor (W bits)
//   out_valid/out_ready  : result handshake; result held until accepted
//   quotient, remainder  : W-bit results
//   div_zero, overflow   : divisor was zero / quotient does not fit in W bits
// Build option: define DIV128_RADIX4_EN to retire two quotient bits per clock (latency W/2).
module div128by64
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam int unsigned CntW = $clog2(W);
  localparam logic [W-1:0] QSat = W'(quot_sat(W));
`ifdef DIV128_RADIX4_EN
  localparam logic [CntW-1:0] CntLast = CntW'(W / 2 - 1);
`else
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);
`endif

  div_state_t      state_q, state_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    qshift_q, qshift_d;
  logic [W-1:0]    divisor_q, divisor_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    quotient_q, quotient_d;
  logic [W-1:0]    remainder_q, remainder_d;
  logic            div_zero_q, div_zero_d;
  logic            overflow_q, overflow_d;

  logic [W-1:0] s1_rem;
  logic         s1_q;
  logic [W-1:0] step_rem;
  logic [W-1:0] step_qshift;

  // The top bit of qshift is the next dividend bit; quotient bits fill in from the bottom.
  div_step #(.W(W)) u_step0 (
    .rem_i     (rem_q),
    .bit_i     (qshift_q[W-1]),
    .divisor_i (divisor_q),
    .rem_o     (s1_rem),
    .q_o       (s1_q)
  );

`ifdef DIV128_RADIX4_EN
  logic [W-1:0] s2_rem;
  logic         s2_q;

  div_step #(.W(W)) u_step1 (
    .rem_i     (s1_rem),
    .bit_i     (qshift_q[W-2]),
    .divisor_i (divisor_q),
    .rem_o     (s2_rem),
    .q_o       (s2_q)
  );

  assign step_rem    = s2_rem;
  assign step_qshift = {qshift_q[W-3:0], s1_q, s2_q};
`else
  assign step_rem    = s1_rem;
  assign step_qshift = {qshift_q[W-2:0], s1_q};
`endif

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    qshift_d    = qshift_q;
    divisor_d   = divisor_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          divisor_d = divisor;
          rem_d     = dividend[2*W-1:W];
          qshift_d  = dividend[W-1:0];
          cnt_d     = '0;
          if (divisor == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            quotient_d  = QSat;
            remainder_d = dividend[W-1:0];
            div_zero_d  = 1'b1;
          end else if (dividend[2*W-1:W] >= divisor) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            quotient_d  = QSat;
            remainder_d = dividend[W-1:0];
            overflow_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d    = step_rem;
        qshift_d = step_qshift;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          quotient_d  = step_qshift;
          remainder_d = step_rem;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          div_zero_d  = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      qshift_q    <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      qshift_q    <= qshift_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_div128by64.sv
// tb_div128by64: directed plus random checks of div128by64 against a plain-arithmetic model.
module tb_div128by64;

  localparam int W = 64;
`ifdef DIV128_RADIX4_EN
  localparam int Lat = W / 2;
`else
  localparam int Lat = W;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_zero;
  logic           overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div128by64 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: the division defined arithmetically, with the saturating special cases.
  function automatic void model(input logic [127:0] a, input logic [63:0] b,
                                output logic [63:0] q, output logic [63:0] r,
                                output logic dz, output logic ov, output int lat);
    logic [127:0] bw;
    bw = {64'd0, b};
    dz = 1'b0;
    ov = 1'b0;
    if (b == 64'd0) begin
      q = '1; r = a[63:0]; dz = 1'b1; lat = 0;
    end else if (a[127:64] >= b) begin
      q = '1; r = a[63:0]; ov = 1'b1; lat = 0;
    end else begin
      q = 64'(a / bw); r = 64'(a % bw); lat = Lat;
    end
  endfunction

  task automatic run_op(input logic [127:0] a, input logic [63:0] b, input int hold,
                        input string tag);
    logic [63:0] eq, er;
    logic        edz, eov;
    int          elat;
    int          k;
    model(a, b, eq, er, edz, eov, elat);
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    chk({tag, " in_ready_before"}, in_ready, 1);
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Operands need not be held after the accept edge.
    dividend = {$urandom(), $urandom(), $urandom(), $urandom()};
    divisor  = {$urandom(), $urandom()};
    chk({tag, " in_ready_busy"}, in_ready, 0);
    k = 0;
    while (!out_valid && k < 200) begin @(posedge clk); #1; k++; end
    chk({tag, " latency"}, k, elat);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_zero"}, div_zero, edz);
    chk({tag, " overflow"}, overflow, eov);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, out_valid, 1);
      chk({tag, " hold_in_ready"}, in_ready, 0);
      chk({tag, " hold_q"}, quotient, eq);
      chk({tag, " hold_r"}, remainder, er);
      chk({tag, " hold_flags"}, {div_zero, overflow}, {edz, eov});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " valid_cleared"}, out_valid, 0);
    chk({tag, " in_ready_after"}, in_ready, 1);
    chk({tag, " flags_cleared"}, {div_zero, overflow}, 2'b00);
  endtask

  initial begin
    logic [127:0] a;
    logic [63:0]  b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst quotient", quotient, 0);
    chk("rst remainder", remainder, 0);
    chk("rst flags", {div_zero, overflow}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release in_ready", in_ready, 1);

    run_op(128'd38, 64'd7, 0, "basic");
    run_op(128'hFFFFFFFFFFFFFFFE0000000000000001, 64'hFFFFFFFFFFFFFFFF, 0, "maxdiv");
    a = 128'(64'h0123456789ABCDEF) * 128'(64'hFEDCBA9876543210);
    run_op(a, 64'hFEDCBA9876543210, 0, "golden");
    run_op(128'h5, 64'd0, 0, "divzero");
    run_op(128'h1_0000000000000000, 64'd1, 0, "ovf");
    run_op(128'd0, 64'd0, 1, "zero_by_zero");
    run_op(128'd38, 64'd7, 5, "backpressure");

    // Abort mid-operation: the partial result must never appear.
    @(negedge clk);
    dividend = 128'd38; divisor = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort release in_ready", in_ready, 1);
    repeat (Lat + 5) @(posedge clk);
    #1;
    chk("abort no result", out_valid, 0);
    run_op(128'd38, 64'd7, 0, "after_abort");

    for (int n = 0; n < 20; n++) begin
      b = {$urandom(), $urandom()};
      if (n % 2 == 0) b = b >> $urandom_range(0, 60);
      a = {$urandom(), $urandom(), $urandom(), $urandom()};
      // Mostly in-range dividends, with the odd special case mixed in.
      if (n % 7 == 3) b = 64'd0;
      else if (n % 7 != 5 && b != 64'd0) a[127:64] = a[127:64] % b;
      run_op(a, b, $urandom_range(0, 3), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
